// File: rtl/regfile_sweep.sv
// ============================================================================
// Module   : regfile_sweep
// Brief    : 2-read/1-write register file with a sequential init sweep after
//            reset and an optional hardwired-zero entry 0.
//            Optional same-cycle write-through: define REGFILE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_sweep #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 4,
  parameter int                ZERO_REG = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] Addr_Rd,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Addr_Ra,
  input  logic [ADDR_W-1:0] Addr_Rb,
  output logic [DATA_W-1:0] Saida_Ra,
  output logic [DATA_W-1:0] Saida_Rb,
  output logic              ready
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam bit              ZR       = (ZERO_REG != 0);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = Addr_Rd;
    wr_data = Write_Data;
    case (state_q)
      ST_INIT: begin
        // Sweep owns the write port; user writes are dropped until RUN.
        wr_en   = 1'b1;
        wr_addr = cnt_q[ADDR_W-1:0];
        wr_data = INIT_VAL;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wr_en = we && !(ZR && (Addr_Rd == '0));
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    if (rst) begin
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage is deliberately not reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    Saida_Ra = '0;
    if ((state_q == ST_RUN) && !(ZR && (Addr_Ra == '0))) begin
      Saida_Ra = mem_q[Addr_Ra];
`ifdef REGFILE_BYPASS_EN
      if (we && (Addr_Ra == Addr_Rd)) begin
        Saida_Ra = Write_Data;
      end
`endif
    end
  end

  always_comb begin
    Saida_Rb = '0;
    if ((state_q == ST_RUN) && !(ZR && (Addr_Rb == '0))) begin
      Saida_Rb = mem_q[Addr_Rb];
`ifdef REGFILE_BYPASS_EN
      if (we && (Addr_Rb == Addr_Rd)) begin
        Saida_Rb = Write_Data;
      end
`endif
    end
  end

  assign ready = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_regfile_sweep.sv
// ============================================================================
// Module   : tb_regfile_sweep
// Brief    : Directed self-checking bench for regfile_sweep; two instances
//            share stimulus, one with ZERO_REG=1 and one with ZERO_REG=0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  Addr_Rd;
  logic [15:0] Write_Data;
  logic [3:0]  Addr_Ra;
  logic [3:0]  Addr_Rb;
  logic [15:0] ra_z, rb_z, ra_n, rb_n;
  logic        ready_z, ready_n;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] IV = 16'hA5A5;

  always #5 clk = ~clk;

  regfile_sweep #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .INIT_VAL(IV)) u_dut_z (
    .clk(clk), .rst(rst), .we(we), .Addr_Rd(Addr_Rd), .Write_Data(Write_Data),
    .Addr_Ra(Addr_Ra), .Addr_Rb(Addr_Rb), .Saida_Ra(ra_z), .Saida_Rb(rb_z),
    .ready(ready_z)
  );

  regfile_sweep #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .INIT_VAL(IV)) u_dut_n (
    .clk(clk), .rst(rst), .we(we), .Addr_Rd(Addr_Rd), .Write_Data(Write_Data),
    .Addr_Ra(Addr_Ra), .Addr_Rb(Addr_Rb), .Saida_Ra(ra_n), .Saida_Rb(rb_n),
    .ready(ready_n)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  initial begin
    rst = 1'b1; we = 1'b0; Addr_Rd = '0; Write_Data = '0; Addr_Ra = 4'd1; Addr_Rb = 4'd2;
    tick();
    tick();
    check("reset_ready", {15'd0, ready_z}, 16'd0);
    check("reset_ra_forced0", ra_z, 16'h0000);
    check("reset_rb_forced0_nz", rb_n, 16'h0000);

    // Sweep; a write to R5 on sweep cycle 3 must be dropped.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      we = (i == 3); Addr_Rd = 4'd5; Write_Data = 16'h0042; Addr_Ra = 4'd5;
      #1;
      check($sformatf("sweep_ready_%0d", i), {15'd0, ready_z}, 16'd0);
      check($sformatf("sweep_ra_zero_%0d", i), ra_z, 16'h0000);
      tick();
    end
    we = 1'b0;
    check("sweep_done_ready", {15'd0, ready_z}, 16'd1);
    check("sweep_done_ready_nz", {15'd0, ready_n}, 16'd1);

    for (int a = 1; a < 16; a++) begin
      Addr_Ra = 4'(a); Addr_Rb = 4'(a);
      #1;
      check($sformatf("init_ra_%0d", a), ra_z, IV);
      check($sformatf("init_rb_%0d", a), rb_z, IV);
    end
    Addr_Ra = 4'd5; #1;
    check("r5_write_dropped", ra_z, IV);
    Addr_Ra = 4'd0; Addr_Rb = 4'd0; #1;
    check("r0_zero_reg", ra_z, 16'h0000);
    check("r0_plain_init", rb_n, IV);

    // Ordinary writes.
    we = 1'b1; Addr_Rd = 4'd3; Write_Data = 16'h1234; tick();
    Addr_Rd = 4'd15; Write_Data = 16'hFFFF; tick();
    we = 1'b0; Addr_Ra = 4'd3; Addr_Rb = 4'd15; #1;
    check("wr_r3", ra_z, 16'h1234);
    check("wr_r15", rb_z, 16'hFFFF);
    check("wr_r3_nz", ra_n, 16'h1234);

    // Entry 0 write.
    we = 1'b1; Addr_Rd = 4'd0; Write_Data = 16'hBEEF; tick();
    we = 1'b0; Addr_Ra = 4'd0; Addr_Rb = 4'd0; #1;
    check("r0_write_zero_reg", ra_z, 16'h0000);
    check("r0_write_plain", ra_n, 16'hBEEF);

    // Same-cycle write versus read.
    we = 1'b1; Addr_Rd = 4'd7; Write_Data = 16'h0000; tick();
    Write_Data = 16'h5555; Addr_Ra = 4'd7; Addr_Rb = 4'd3; #1;
    check("same_cycle_r7", ra_z, BYP ? 16'h5555 : 16'h0000);
    check("same_cycle_other_port", rb_z, 16'h1234);
    tick();
    we = 1'b0; #1;
    check("next_cycle_r7", ra_z, 16'h5555);

    we = 1'b1; Addr_Rd = 4'd0; Write_Data = 16'h1111; Addr_Ra = 4'd0; #1;
    check("same_cycle_r0_zero_reg", ra_z, 16'h0000);
    check("same_cycle_r0_plain", ra_n, BYP ? 16'h1111 : 16'hBEEF);
    tick();
    we = 1'b0; #1;
    check("r0_plain_after", ra_n, 16'h1111);

    // Reset in RUN, then a second reset at sweep cycle 7.
    rst = 1'b1; tick();
    check("rst_in_run_ready", {15'd0, ready_z}, 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_sweep_ready", {15'd0, ready_z}, 16'd0);
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("restart_ready_%0d", i), {15'd0, ready_z}, 16'd0);
      tick();
    end
    check("restart_done_ready", {15'd0, ready_z}, 16'd1);
    Addr_Ra = 4'd3; Addr_Rb = 4'd7; #1;
    check("restart_r3_reinit", ra_z, IV);
    check("restart_r7_reinit", rb_z, IV);
    Addr_Ra = 4'd0; #1;
    check("restart_r0_plain_reinit", ra_n, IV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
